// File: rtl/shift_iter_if.sv
// shift_iter_if: request/result bundle for the iterative shifter.
//   master: drives start, in, cnt, op; observes busy, done, out
//   slave : observes start, in, cnt, op; drives busy, done, out
//   start - request, honoured only while the shifter is idle
//   in    - 16-bit operand
//   cnt   - shift amount 0..15
//   op    - 00 ROL, 01 SLL, 10 ROR, 11 SRA
//   busy  - shifter is working on a request
//   done  - one-cycle pulse, out carries the new result
//   out   - last result, held between operations
interface shift_iter_if;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;

  logic          start;
  logic [DW-1:0] in;
  logic [CW-1:0] cnt;
  logic [1:0]    op;
  logic          busy;
  logic          done;
  logic [DW-1:0] out;

  modport master (
    output start, in, cnt, op,
    input  busy, done, out
  );

  modport slave (
    input  start, in, cnt, op,
    output busy, done, out
  );
endinterface

// File: rtl/shift_iter.sv
// shift_iter: multi-cycle shifter moving the operand one bit per clock.
// Ports:
//   clk - system clock, rising edge
//   rst - synchronous active-high reset
//   bus - shift_iter_if.slave (start/in/cnt/op in, busy/done/out out)
// Build option:
//   SHIFT_ITER_ROTATE_EN - when defined, op 00/10 rotate left/right;
//                          otherwise they act as logical left/right shifts.
// A request with cnt=N raises done N+1 cycles after start is sampled.
module shift_iter (
  input  logic         clk,
  input  logic         rst,
  shift_iter_if.slave  bus
);
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] data;
  logic [CW-1:0] remaining;
  logic [1:0]    op_q;
  logic [DW-1:0] out_q;
  logic          busy_q;
  logic          done_q;
  logic [DW-1:0] step_c;

  // Single-bit barrel stage; rotates degrade to zero-fill shifts when disabled.
  function automatic logic [DW-1:0] shift1(input logic [DW-1:0] d,
                                           input logic [1:0]    o);
    logic [DW-1:0] r;
    r = d;
    case (o)
`ifdef SHIFT_ITER_ROTATE_EN
      OP_ROL:  r = {d[DW-2:0], d[DW-1]};
      OP_ROR:  r = {d[0], d[DW-1:1]};
`else
      OP_ROL:  r = {d[DW-2:0], 1'b0};
      OP_ROR:  r = {1'b0, d[DW-1:1]};
`endif
      OP_SLL:  r = {d[DW-2:0], 1'b0};
      OP_SRA:  r = {d[DW-1], d[DW-1:1]};
      default: r = d;
    endcase
    return r;
  endfunction

  assign step_c = shift1(data, op_q);

  // Control FSM with registered busy/done/out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      data      <= '0;
      remaining <= '0;
      op_q      <= OP_ROL;
      out_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            data      <= bus.in;
            remaining <= bus.cnt;
            op_q      <= bus.op;
            busy_q    <= 1'b1;
            if (bus.cnt == '0) begin
              // Zero-length request completes on the next cycle unchanged.
              state  <= DONE;
              out_q  <= bus.in;
              done_q <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end

        SHIFT: begin
          data      <= step_c;
          remaining <= remaining - CW'(1);
          if (remaining == CW'(1)) begin
            // Last step: publish the shifted value as it is formed.
            state  <= DONE;
            out_q  <= step_c;
            done_q <= 1'b1;
          end
        end

        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.out  = out_q;
endmodule

// File: doc/shift_iter.md
SHIFT_ITER -- requirements
Module: shift_iter

Interface
REQ-001 Parameters: none; datapath fixed at 16 bits, count fixed at 4 bits.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 in  input  16  operand; captured on accepted start.
REQ-006 cnt  input  4  shift amount 0..15; captured on accepted start.
REQ-007 op  input  2  00 ROL, 01 SLL, 10 ROR, 11 SRA; captured on accepted start.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  one-cycle pulse; result valid on out.
REQ-010 out  output  16  result register; holds last result until next accepted start.

Function
REQ-011 Block SHALL perform a multi-cycle shift of exactly one bit position per clock, the sequential counterpart of a single-bit barrel stage.
REQ-012 FSM SHALL have states IDLE, SHIFT, DONE.
REQ-013 IDLE: start=1 SHALL load data<=in, remaining<=cnt, op_q<=op; next state SHIFT if cnt!=0, else DONE.
REQ-014 IDLE: start=0 SHALL keep state IDLE and hold out.
REQ-015 SHIFT: each cycle SHALL shift data one bit per op_q and decrement remaining; when remaining==1, next state DONE.
REQ-016 SLL SHALL fill bit 0 with 0; SRA SHALL replicate bit 15; ROL SHALL move bit 15 to bit 0; ROR SHALL move bit 0 to bit 15.
REQ-017 DONE: done=1 for exactly one cycle, out equals final data; next state IDLE unconditionally.
REQ-018 Latency: done SHALL be high in cycle start+N+1 for cnt=N (N=0 gives 1 cycle).
REQ-019 start while busy=1 (SHIFT or DONE) SHALL be ignored with no effect on operands or result.
REQ-020 Operand inputs changing after acceptance SHALL NOT affect the in-flight result.
REQ-021 out SHALL be registered; it updates only at the edge entering DONE and is stable otherwise.
REQ-022 Back-to-back: a start asserted in the cycle after done (state IDLE) SHALL be accepted.

Reset
REQ-023 rst=1 at a rising edge SHALL force state IDLE, out=16'h0000, done=0, busy=0, remaining=0, data=0.
REQ-024 rst SHALL take priority over start and over any in-progress shift; an aborted operation produces no done pulse.
REQ-025 First start SHALL be accepted in the first cycle with rst=0.

Configuration
REQ-026 Macro SHIFT_ITER_ROTATE_EN SHALL control rotate support.
REQ-027 Defined: ROL and ROR SHALL behave per REQ-016.
REQ-028 Not defined: op 00 SHALL behave as SLL and op 10 as logical right shift (fill 0); timing and handshake unchanged.

Verification
REQ-029 SLL in=0x0001 cnt=4 -> done 5 cycles after start, out=0x0010, busy high for 5 cycles.
REQ-030 SRA in=0x8000 cnt=15 -> done at cycle 16, out=0xFFFF; SRA in=0x4000 cnt=2 -> out=0x1000.
REQ-031 ROL in=0x8001 cnt=1 -> out=0x0003 with SHIFT_ITER_ROTATE_EN, 0x0002 without; ROR in=0x0001 cnt=4 -> 0x1000 with macro, 0x0000 without.
REQ-032 cnt=0 any op in=0xA5A5 -> done next cycle, out=0xA5A5.
REQ-033 SLL in=0x00FF cnt=8, second start (in=0x1234) pulsed in SHIFT -> out=0xFF00, second request dropped; rst asserted mid-SHIFT -> next cycle out=0x0000, busy=0, no done pulse.
